// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS pipeline: ALU operations, opcode/funct
// encodings, the ID/EX control bundle and immediate-extension helpers.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_NOP = 4'd5
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Control part of the ID/EX bundle; XLEN-wide data travels beside it.
    typedef struct packed {
        alu_op_e    op;
        logic       use_imm;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
    } id_ex_t;

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// NREG x XLEN register file: two combinational read ports, one write port,
// register 0 hardwired to zero and write-through bypass on both read ports.
module mips_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra_addr,
    output logic [XLEN-1:0] ra_data,
    input  logic [4:0]      rb_addr,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr_ok;

    assign wr_ok = we && (waddr != 5'd0) && (32'(waddr) < NREG);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[waddr[AW-1:0]] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        ra_data = '0;
        if ((ra_addr != 5'd0) && (32'(ra_addr) < NREG)) begin
            ra_data = (wr_ok && (waddr == ra_addr)) ? wdata : regs_q[ra_addr[AW-1:0]];
        end
    end

    always_comb begin
        rb_data = '0;
        if ((rb_addr != 5'd0) && (32'(rb_addr) < NREG)) begin
            rb_data = (wr_ok && (waddr == rb_addr)) ? wdata : regs_q[rb_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/mips_decode_stage.sv
// Pipelined MIPS instruction decode: R/I-type decode, register read with bypass,
// load-use stall and a registered ID/EX bundle behind a valid/ready handshake.
module mips_decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [3:0]      ex_op,
    output logic [XLEN-1:0] ex_rs_val,
    output logic [XLEN-1:0] ex_rt_val,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_use_imm,
    output logic [4:0]      ex_dst,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_illegal,
    output logic [XLEN-1:0] ex_pc
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        unused_shamt;

    assign opcode       = if_instr[31:26];
    assign rs           = if_instr[25:21];
    assign rt           = if_instr[20:16];
    assign rd           = if_instr[15:11];
    assign funct        = if_instr[5:0];
    assign imm16        = if_instr[15:0];
    assign unused_shamt = ^if_instr[10:6];

    logic [XLEN-1:0] rs_rdata;
    logic [XLEN-1:0] rt_rdata;

    mips_regfile #(
        .XLEN(XLEN),
        .NREG(NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst),
        .ra_addr(rs),
        .ra_data(rs_rdata),
        .rb_addr(rt),
        .rb_data(rt_rdata),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    function automatic logic reg_ok(input logic [4:0] r);
        return 32'(r) < NREG;
    endfunction

    id_ex_t          dec;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_rs;
    logic [XLEN-1:0] dec_rt;
    logic            dec_bad;

    always_comb begin
        dec      = '0;
        dec.op   = ALU_NOP;
        dec_imm  = '0;
        dec_bad  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.dst       = rd;
                case (funct)
                    FN_ADD:  dec.op = ALU_ADD;
                    FN_SUB:  dec.op = ALU_SUB;
                    FN_AND:  dec.op = ALU_AND;
                    FN_OR:   dec.op = ALU_OR;
                    FN_SLT:  dec.op = ALU_SLT;
                    default: dec_bad = 1'b1;
                endcase
                if (!reg_ok(rd)) dec_bad = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SW: begin
                dec.op        = ALU_ADD;
                dec_imm       = XLEN'(signed'(sext(imm16)));
                dec.use_imm   = 1'b1;
                dec.dst       = rt;
                dec.reg_write = (opcode != OP_SW);
                dec.mem_read  = (opcode == OP_LW);
                dec.mem_write = (opcode == OP_SW);
            end
            OP_ANDI, OP_ORI: begin
                dec.op        = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
                dec_imm       = XLEN'(zext(imm16));
                dec.use_imm   = 1'b1;
                dec.dst       = rt;
                dec.reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec.op     = ALU_SUB;
                dec.branch = 1'b1;
                dec_imm    = XLEN'(signed'(sext(imm16))) << 2;
            end
            default: dec_bad = 1'b1;
        endcase
        if (!reg_ok(rs) || !reg_ok(rt)) dec_bad = 1'b1;
        dec_rs = rs_rdata;
        dec_rt = rt_rdata;
        // Illegal instructions issue a clean, side-effect-free bundle.
        if (dec_bad) begin
            dec         = '0;
            dec.op      = ALU_NOP;
            dec.illegal = 1'b1;
            dec_imm     = '0;
            dec_rs      = '0;
            dec_rt      = '0;
        end
    end

    logic            ex_valid_q, ex_valid_d;
    id_ex_t          ex_q, ex_d;
    logic [XLEN-1:0] rs_val_q, rs_val_d;
    logic [XLEN-1:0] rt_val_q, rt_val_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic reads_rt;
    logic hazard;
    logic accept;

    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard   = if_valid && ex_valid_q && ex_q.mem_read && (ex_q.dst != 5'd0) &&
                      ((rs == ex_q.dst) || (reads_rt && (rt == ex_q.dst)));
    assign id_ready = rst && !hazard && (!ex_valid_q || ex_ready);
    assign accept   = if_valid && id_ready;

    // A stalled slot that drains issues as a bubble; the stalled
    // instruction is then accepted once the load has left.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        rs_val_d   = rs_val_q;
        rt_val_d   = rt_val_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        if (!ex_valid_q || ex_ready) begin
            ex_valid_d = accept;
            if (accept) begin
                ex_d     = dec;
                rs_val_d = dec_rs;
                rt_val_d = dec_rt;
                imm_d    = dec_imm;
                pc_d     = if_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            rs_val_q   <= rs_val_d;
            rt_val_q   <= rt_val_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op        = ex_q.op;
    assign ex_rs_val    = rs_val_q;
    assign ex_rt_val    = rt_val_q;
    assign ex_imm       = imm_q;
    assign ex_use_imm   = ex_q.use_imm;
    assign ex_dst       = ex_q.dst;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_branch    = ex_q.branch;
    assign ex_illegal   = ex_q.illegal;
    assign ex_pc        = pc_q;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Scoreboard bench for mips_decode_stage: directed scenarios plus random traffic
// against a behavioural decode/register model, with NREG=16.
module tb_mips_decode_stage;
    import mips_pkg::*;

    localparam int unsigned NR = 16;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic        ex_use_imm;
    logic [4:0]  ex_dst;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_illegal;
    logic [31:0] ex_pc;

    mips_decode_stage #(
        .XLEN(32),
        .NREG(NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_op       (ex_op),
        .ex_rs_val   (ex_rs_val),
        .ex_rt_val   (ex_rt_val),
        .ex_imm      (ex_imm),
        .ex_use_imm  (ex_use_imm),
        .ex_dst      (ex_dst),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read (ex_mem_read),
        .ex_mem_write(ex_mem_write),
        .ex_branch   (ex_branch),
        .ex_illegal  (ex_illegal),
        .ex_pc       (ex_pc)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [31:0] m_regs [32];
    logic        m_valid;
    exp_t        m_hold;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference decode written straight from the instruction table.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        ok;
        int          s;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        opc = ins[31:26]; fn = ins[5:0];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        s  = $signed(ins[15:0]);
        e  = '0;
        e.pc = pc; e.rs_val = a; e.rt_val = b;
        ok = 1'b1;
        case (opc)
            6'h00: begin
                e.rw = 1'b1; e.dst = rd;
                case (fn)
                    6'h20: e.op = ALU_ADD;
                    6'h22: e.op = ALU_SUB;
                    6'h24: e.op = ALU_AND;
                    6'h25: e.op = ALU_OR;
                    6'h2A: e.op = ALU_SLT;
                    default: ok = 1'b0;
                endcase
                if (rd >= NR) ok = 1'b0;
            end
            6'h08: begin e.op = ALU_ADD; e.imm = 32'(s); e.use_imm = 1; e.rw = 1; e.dst = rt; end
            6'h0C: begin e.op = ALU_AND; e.imm = {16'h0, ins[15:0]}; e.use_imm = 1; e.rw = 1; e.dst = rt; end
            6'h0D: begin e.op = ALU_OR;  e.imm = {16'h0, ins[15:0]}; e.use_imm = 1; e.rw = 1; e.dst = rt; end
            6'h23: begin e.op = ALU_ADD; e.imm = 32'(s); e.use_imm = 1; e.rw = 1; e.mr = 1; e.dst = rt; end
            6'h2B: begin e.op = ALU_ADD; e.imm = 32'(s); e.use_imm = 1; e.mw = 1; e.dst = rt; end
            6'h04: begin e.op = ALU_SUB; e.imm = 32'(s * 4); e.br = 1; end
            default: ok = 1'b0;
        endcase
        if (rs >= NR || rt >= NR) ok = 1'b0;
        if (!ok) begin
            e = '0; e.pc = pc; e.op = ALU_NOP; e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rdv(input logic [4:0] r, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0 || r >= NR) return 32'h0;
        if (we && wa == r) return wd;
        return m_regs[r];
    endfunction

    // One cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rdy, output logic acc, output logic drdy);
        logic haz, exp_rdy, reads_rt;
        exp_t e;
        if_valid = v; if_instr = ins; if_pc = pc;
        wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = rdy;
        reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
        haz = v && m_valid && m_hold.mr && (m_hold.dst != 0) &&
              ((ins[25:21] == m_hold.dst) || (reads_rt && ins[20:16] == m_hold.dst));
        exp_rdy = !haz && (!m_valid || rdy);
        acc = v && exp_rdy;
        e = '0;
        if (acc) begin
            e = model(ins, pc, rdv(ins[25:21], we, wa, wd), rdv(ins[20:16], we, wa, wd));
            sb.push_back(e);
        end
        #2;
        drdy = id_ready;
        check("id_ready", {31'h0, id_ready}, {31'h0, exp_rdy});
        check("ex_valid", {31'h0, ex_valid}, {31'h0, m_valid});
        if (!m_valid || rdy) begin
            m_valid = acc;
            if (acc) m_hold = e;
        end
        if (we && wa != 0 && wa < NR) m_regs[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic a, r;
        step(1'b0, 32'h0, 32'h0, we, wa, wd, 1'b1, a, r);
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, output int stalls);
        logic a, r, done;
        stalls = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(1'b1, ins, pc, we, wa, wd, 1'b1, a, r);
            if (!r) stalls++;
            done = a;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: instr %h got not accepted required accepted", ins);
        end
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] opc, fn;
        case ($urandom_range(0, 9))
            0, 1:    opc = 6'h00;
            2:       opc = 6'h08;
            3:       opc = 6'h0C;
            4:       opc = 6'h0D;
            5, 6:    opc = 6'h23;
            7:       opc = 6'h2B;
            8:       opc = 6'h04;
            default: opc = 6'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0:       fn = 6'h20;
            1:       fn = 6'h22;
            2:       fn = 6'h24;
            3:       fn = 6'h25;
            4:       fn = 6'h2A;
            default: fn = 6'($urandom);
        endcase
        if (opc == 6'h00) return {opc, rreg(), rreg(), rreg(), 5'($urandom), fn};
        return {opc, rreg(), rreg(), 16'($urandom)};
    endfunction

    always @(negedge clk) begin
        exp_t got;
        if (rst && ex_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL ex_unexpected: got bundle pc %h required no valid bundle", ex_pc);
            end else begin
                got = '{op: ex_op, rs_val: ex_rs_val, rt_val: ex_rt_val, imm: ex_imm,
                        use_imm: ex_use_imm, dst: ex_dst, rw: ex_reg_write, mr: ex_mem_read,
                        mw: ex_mem_write, br: ex_branch, ill: ex_illegal, pc: ex_pc};
                if (got !== sb[0]) begin
                    n_fail++;
                    $display("FAIL bundle: got %h required %h (pc %h)", got, sb[0], sb[0].pc);
                end
                if (ex_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int stalls;
        logic a, r;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_hold  = '0;
        rst = 1'b0;
        if_valid = 0; if_instr = '0; if_pc = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
        #2;
        check("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
        check("rst_id_ready", {31'h0, id_ready}, 32'h0);
        check("rst_ex_op", {28'h0, ex_op}, 32'h0);
        check("rst_ex_pc", ex_pc, 32'h0);
        check("rst_ex_imm", ex_imm, 32'h0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        idle(1'b1, 5'd10, 32'd3);
        idle(1'b1, 5'd11, 32'd4);
        send(32'h014B4820, 32'h100, 0, 0, 0, stalls);
        send(32'h21490005, 32'h104, 0, 0, 0, stalls);
        idle(0, 0, 0);

        step(1'b1, 32'h014B4820, 32'h200, 0, 0, 0, 1'b0, a, r);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h014B4824, 32'h204, 0, 0, 0, 1'b0, a, r);
            if (!r) stalls++;
        end
        check("bp_stall_cycles", 32'(stalls), 32'd3);
        send(32'h014B4824, 32'h204, 0, 0, 0, stalls);
        check("bp_release_stalls", 32'(stalls), 32'd0);
        idle(0, 0, 0);

        send(32'h8D490000, 32'h300, 0, 0, 0, stalls);
        send(32'h012B5020, 32'h304, 0, 0, 0, stalls);
        check("load_use_stalls", 32'(stalls), 32'd1);
        idle(0, 0, 0);

        send(32'h014B4820, 32'h400, 1'b1, 5'd10, 32'h0000DEAD, stalls);
        idle(1'b1, 5'd0, 32'h00001234);
        send(32'h000B4820, 32'h404, 0, 0, 0, stalls);

        send(32'h014B483F, 32'h500, 0, 0, 0, stalls);
        send(32'h014B8820, 32'h504, 0, 0, 0, stalls);
        send(32'h31498000, 32'h508, 0, 0, 0, stalls);
        send(32'h21498000, 32'h50C, 0, 0, 0, stalls);
        send(32'h114BFFFF, 32'h510, 0, 0, 0, stalls);

        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 20)), $urandom,
                 $urandom_range(0, 9) < 7, a, r);
            if (c == 1000) begin
                #2;
                rst = 1'b0; if_valid = 1'b0; wb_en = 1'b0;
                #1;
                check("midrst_ex_valid", {31'h0, ex_valid}, 32'h0);
                check("midrst_id_ready", {31'h0, id_ready}, 32'h0);
                check("midrst_ex_pc", ex_pc, 32'h0);
                m_valid = 1'b0;
                for (int i = 0; i < 32; i++) m_regs[i] = '0;
                sb.delete();
                @(posedge clk);
                #3 rst = 1'b1;
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 3; i++) idle(0, 0, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
